life_array_reader: RTL



---
 rtl/life_array_reader_if.sv | 37 +++
 rtl/life_array_reader.sv | 129 ++++++++++++
 2 files changed

// File: rtl/life_array_reader_if.sv
// Bundle of the life-array read port and the row-stream handshake for life_array_reader.
// pop_count exists only when LIFE_READER_POPCOUNT_EN is defined.
interface life_array_reader_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [1:0]  valo_selector;
  logic [15:0] valo;
  logic [7:0]  row_data;
  logic [2:0]  row_index;
  logic        row_valid;
  logic        row_ready;
  logic        frame_last;
`ifdef LIFE_READER_POPCOUNT_EN
  logic [6:0]  pop_count;
`endif

`ifdef LIFE_READER_POPCOUNT_EN
  modport master (
    input  start, valo, row_ready,
    output busy, done, valo_selector, row_data, row_index, row_valid, frame_last, pop_count
  );
  modport slave (
    output start, valo, row_ready,
    input  busy, done, valo_selector, row_data, row_index, row_valid, frame_last, pop_count
  );
`else
  modport master (
    input  start, valo, row_ready,
    output busy, done, valo_selector, row_data, row_index, row_valid, frame_last
  );
  modport slave (
    output start, valo, row_ready,
    input  busy, done, valo_selector, row_data, row_index, row_valid, frame_last
  );
`endif
endinterface

// File: rtl/life_array_reader.sv
// Sweeps the 8x8 life array's quadrant port into a frame snapshot and streams it row by row.
// Optional live-cell count output enabled by LIFE_READER_POPCOUNT_EN.
module life_array_reader #(
  parameter int unsigned READ_LAT = 1
) (
  input logic           clk,
  input logic           reset,
  life_array_reader_if.master bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StSweep = 2'd1;
  localparam logic [1:0] StEmit  = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  localparam logic [1:0] LatLast = 2'(READ_LAT - 1);

  logic [1:0]       state_q, state_d;
  logic [1:0]       quad_q, quad_d;
  logic [1:0]       lat_q, lat_d;
  logic [2:0]       row_q, row_d;
  logic [3:0][15:0] frame_q, frame_d;
  logic [7:0]       row_bits;

`ifdef LIFE_READER_POPCOUNT_EN
  logic [6:0] pop_q, pop_d;

  function automatic logic [4:0] popcount16(input logic [15:0] w);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(w[i]);
    return n;
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    quad_d  = quad_q;
    lat_d   = lat_q;
    row_d   = row_q;
    frame_d = frame_q;
`ifdef LIFE_READER_POPCOUNT_EN
    pop_d   = pop_q;
`endif
    case (state_q)
      // FIN accepts start too, so back-to-back frames need no idle gap
      StIdle, StFin: begin
        if (bus.start) begin
          state_d = StSweep;
          quad_d  = 2'd0;
          lat_d   = 2'd0;
`ifdef LIFE_READER_POPCOUNT_EN
          pop_d   = '0;
`endif
        end else begin
          state_d = StIdle;
        end
      end
      StSweep: begin
        if (lat_q == LatLast) begin
          frame_d[quad_q] = bus.valo;
`ifdef LIFE_READER_POPCOUNT_EN
          pop_d = pop_q + 7'(popcount16(bus.valo));
`endif
          lat_d = 2'd0;
          if (quad_q == 2'd3) begin
            state_d = StEmit;
            row_d   = 3'd0;
          end else begin
            quad_d = quad_q + 2'd1;
          end
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      StEmit: begin
        if (bus.row_ready) begin
          row_d = row_q + 3'd1;
          if (row_q == 3'd7) state_d = StFin;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      quad_q  <= 2'd0;
      lat_q   <= 2'd0;
      row_q   <= 3'd0;
      frame_q <= '0;
`ifdef LIFE_READER_POPCOUNT_EN
      pop_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      quad_q  <= quad_d;
      lat_q   <= lat_d;
      row_q   <= row_d;
      frame_q <= frame_d;
`ifdef LIFE_READER_POPCOUNT_EN
      pop_q   <= pop_d;
`endif
    end
  end

  // Cell (R,C) lives in quadrant {C>=4, R>=4} at bit (C%4)*4 + R%4
  always_comb begin
    row_bits = '0;
    for (int c = 0; c < 8; c++) begin
      row_bits[c] = frame_q[{c[2], row_q[2]}][{c[1:0], row_q[1:0]}];
    end
  end

  always_comb begin
    bus.busy          = (state_q != StIdle);
    bus.done          = (state_q == StFin);
    bus.valo_selector = (state_q == StSweep) ? quad_q : 2'b00;
    bus.row_valid     = (state_q == StEmit);
    bus.row_index     = row_q;
    bus.row_data      = (state_q == StEmit) ? row_bits : 8'h00;
    bus.frame_last    = (state_q == StEmit) && (row_q == 3'd7);
`ifdef LIFE_READER_POPCOUNT_EN
    bus.pop_count     = pop_q;
`endif
  end

endmodule
